// File: rtl/key_schedule_ctrl.sv
// Iterative AES key expansion (NK = 4/6/8), one 32-bit word per clock, with a registered round-key read port.
// Optional build macro KEYSCHED_ZEROIZE_EN adds a zeroize input that also lets rst clear the word store.
module key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic            zeroize,
`endif
  input  logic [32*NK-1:0] key_in,
  input  logic [3:0]      rd_round,
  output logic            busy,
  output logic            key_ready,
  output logic [127:0]    rd_key,
  output logic            rd_valid
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = NB * (NR + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  generate
    if (!(NK == 4 || NK == 6 || NK == 8) || NB != 4) begin : g_bad_cfg
      $error("key_schedule_ctrl: NK must be 4, 6 or 8 and NB must be 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform, so no ROM table is needed.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [1:0]            state;
  logic [5:0]            wr_ptr;
  logic [2:0]            col;        // wr_ptr mod NK, tracked incrementally to avoid a divider
  logic [7:0]            rcon;
  logic [31:0]           win [NK];   // last NK words: win[0] = w[wr_ptr-NK], win[NK-1] = w[wr_ptr-1]
  logic [TOTAL-1:0][31:0] w;

  logic        clr;
  logic        load;
  logic        step;
  logic        last;
  logic [31:0] prev;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t;
  logic [31:0] new_word;
  logic        rd_ok;
  logic [5:0]  base;

`ifdef KEYSCHED_ZEROIZE_EN
  assign clr = rst | zeroize;
`else
  assign clr = rst;
`endif

  assign load = !clr && start && (state != EXPAND);
  assign step = !clr && (state == EXPAND);
  assign last = (wr_ptr == 6'(TOTAL - 1));

  // A single SubWord unit is shared between the RotWord and the NK=8 mid-key cases.
  always_comb begin
    prev    = win[NK-1];
    sub_in  = (col == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = sub_word(sub_in);
    t       = prev;
    if (col == 3'd0)
      t = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && col == 3'd4)
      t = sub_out;
    new_word = win[0] ^ t;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      wr_ptr    <= '0;
      col       <= '0;
      rcon      <= 8'h01;
    end else if (load) begin
      state     <= EXPAND;
      busy      <= 1'b1;
      key_ready <= 1'b0;
      wr_ptr    <= 6'(NK);
      col       <= '0;
      rcon      <= 8'h01;
    end else if (step) begin
      wr_ptr <= wr_ptr + 6'd1;
      col    <= (col == 3'(NK - 1)) ? 3'd0 : col + 3'd1;
      if (col == 3'd0) rcon <= xtime(rcon);
      if (last) begin
        state     <= READY;
        busy      <= 1'b0;
        key_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++) win[k] <= key_in[32*(NK-k)-1 -: 32];
    end else if (step) begin
      for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
      win[NK-1] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
`ifdef KEYSCHED_ZEROIZE_EN
    if (clr)
      w <= '0;
    else
`endif
    if (load) begin
      for (int k = 0; k < NK; k++) w[k] <= key_in[32*(NK-k)-1 -: 32];
    end else if (step) begin
      w[wr_ptr] <= new_word;
    end
  end

  // A round is readable once its last word sits below wr_ptr; the reset of wr_ptr on start
  // is what keeps stale store contents from ever being flagged valid.
  assign rd_ok = (rd_round <= 4'(NR)) && ({rd_round, 2'b11} < wr_ptr);
  assign base  = rd_ok ? {rd_round, 2'b00} : 6'd0;

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_key   <= rd_ok ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : 128'h0;
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

  localparam logic [127:0] K4     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K6     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R4_1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R4_2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R4_10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R6_12  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R8_2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R8_14  = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst;
  logic zeroize;
  logic start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [3:0] rr4, rr6, rr8;
  logic busy4, busy6, busy8, kr4, kr6, kr8, rv4, rv6, rv8;
  logic [127:0] rk4, rk6, rk8;

  always #5 clk = ~clk;

  key_schedule_ctrl #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in(key4), .rd_round(rr4), .busy(busy4), .key_ready(kr4), .rd_key(rk4), .rd_valid(rv4));

  key_schedule_ctrl #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .start(start6),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in(key6), .rd_round(rr6), .busy(busy6), .key_ready(kr6), .rd_key(rk6), .rd_valid(rv6));

  key_schedule_ctrl #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in(key8), .rd_round(rr8), .busy(busy8), .key_ready(kr8), .rd_key(rk8), .rd_valid(rv8));

  typedef struct {
    int           inst;
    int           due;
    int           kind;
    logic [128:0] exp;
  } item_t;

  item_t sb[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [128:0] actual(input int inst, input int kind);
    logic [128:0] a;
    a = '0;
    case (inst)
      4: a = (kind == 0) ? {rv4, rk4} : (kind == 1) ? 129'(busy4) : 129'(kr4);
      6: a = (kind == 0) ? {rv6, rk6} : (kind == 1) ? 129'(busy6) : 129'(kr6);
      default: a = (kind == 0) ? {rv8, rk8} : (kind == 1) ? 129'(busy8) : 129'(kr8);
    endcase
    return a;
  endfunction

  function automatic string kname(input int kind);
    return (kind == 0) ? "rd_valid/rd_key" : (kind == 1) ? "busy" : "key_ready";
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [128:0] a;
        a = actual(sb[i].inst, sb[i].kind);
        n_tests++;
        if (a !== sb[i].exp) begin
          n_fail++;
          $display("FAIL nk%0d %s cyc %0d: got %h want %h",
                   sb[i].inst, kname(sb[i].kind), cyc, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int inst, input int dly, input int kind, input logic [128:0] exp);
    item_t it;
    it.inst = inst;
    it.due  = cyc + dly;
    it.kind = kind;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; zeroize = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = K4; key6 = K6; key8 = K8;
    rr4 = 4'd0; rr6 = 4'd0; rr8 = 4'd0;
    tick(3);
    for (int n = 4; n <= 8; n += 2) begin
      expect_at(n, 1, 1, 129'(0));
      expect_at(n, 1, 2, 129'(0));
      expect_at(n, 1, 0, 129'(0));
    end
    tick(1);
    rst = 1'b0;
    tick(1);

    rr4 = 4'd1; rr6 = 4'd0;
    start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
    expect_at(4, 1, 1, 129'(1));
    expect_at(4, 1, 2, 129'(0));
    expect_at(4, 5, 0, 129'(0));
    expect_at(4, 6, 0, {1'b1, R4_1});
    expect_at(4, 40, 2, 129'(0));
    expect_at(4, 41, 2, 129'(1));
    expect_at(4, 41, 1, 129'(0));
    expect_at(6, 1, 0, 129'(0));
    expect_at(6, 2, 0, {1'b1, K6[191:64]});
    expect_at(6, 46, 2, 129'(0));
    expect_at(6, 47, 2, 129'(1));
    expect_at(8, 1, 1, 129'(1));
    expect_at(8, 52, 2, 129'(0));
    expect_at(8, 53, 2, 129'(1));
    tick(1);
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    tick(19);
    start4 = 1'b1;
    expect_at(4, 1, 1, 129'(1));
    tick(1);
    start4 = 1'b0;
    tick(40);

    n_tests++;
    if (kr4 !== 1'b1) begin n_fail++; $display("FAIL nk4 key_ready not set after expansion"); end
    n_tests++;
    if (kr6 !== 1'b1) begin n_fail++; $display("FAIL nk6 key_ready not set after expansion"); end
    n_tests++;
    if (kr8 !== 1'b1) begin n_fail++; $display("FAIL nk8 key_ready not set after expansion"); end
    n_tests++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL nk4 busy still set after expansion"); end
    n_tests++;
    if (busy6 !== 1'b0) begin n_fail++; $display("FAIL nk6 busy still set after expansion"); end
    n_tests++;
    if (busy8 !== 1'b0) begin n_fail++; $display("FAIL nk8 busy still set after expansion"); end

    rr4 = 4'd10; rr6 = 4'd12; rr8 = 4'd14;
    expect_at(4, 1, 0, {1'b1, R4_10});
    expect_at(6, 1, 0, {1'b1, R6_12});
    expect_at(8, 1, 0, {1'b1, R8_14});
    tick(1);
    rr4 = 4'd11; rr8 = 4'd1;
    expect_at(4, 1, 0, 129'(0));
    expect_at(8, 1, 0, {1'b1, K8[127:0]});
    tick(1);
    rr4 = 4'd2; rr6 = 4'd15; rr8 = 4'd2;
    expect_at(4, 1, 0, {1'b1, R4_2});
    expect_at(6, 1, 0, 129'(0));
    expect_at(8, 1, 0, {1'b1, R8_2});
    tick(1);
    rr4 = 4'd0; rr8 = 4'd0;
    expect_at(4, 1, 0, {1'b1, K4});
    expect_at(8, 1, 0, {1'b1, K8[255:128]});
    tick(1);

    rr4 = 4'd10;
    start4 = 1'b1;
    expect_at(4, 1, 1, 129'(1));
    expect_at(4, 1, 2, 129'(0));
    expect_at(4, 2, 0, 129'(0));
    tick(1);
    start4 = 1'b0;
    tick(19);
    rst = 1'b1;
    expect_at(4, 1, 1, 129'(0));
    expect_at(4, 1, 2, 129'(0));
    expect_at(4, 1, 0, 129'(0));
    expect_at(8, 1, 2, 129'(0));
    tick(1);
    rst = 1'b0;
    expect_at(4, 2, 1, 129'(0));
    expect_at(4, 2, 0, 129'(0));
    tick(3);

`ifdef KEYSCHED_ZEROIZE_EN
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(45);
    rr4 = 4'd10;
    zeroize = 1'b1; start4 = 1'b1;
    expect_at(4, 1, 1, 129'(0));
    expect_at(4, 1, 2, 129'(0));
    expect_at(4, 1, 0, 129'(0));
    tick(1);
    zeroize = 1'b0; start4 = 1'b0;
    expect_at(4, 1, 1, 129'(0));
    expect_at(4, 1, 0, 129'(0));
    tick(1);
    rr4 = 4'd0;
    expect_at(4, 1, 0, 129'(0));
    tick(1);
`endif

    tick(3);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL nk%0d %s never checked (due %0d)", sb[i].inst, kname(sb[i].kind), sb[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
